// File: rtl/alu_operand_loader_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_loader_pkg
// Shared definitions for the ALU operand front end: the ALU opcode values
// a user dials in on the switches, and the loader FSM state encoding that
// is also exported on o_state for the debug LEDs.
// ---------------------------------------------------------------------------
package alu_operand_loader_pkg;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

   typedef enum logic [1:0] {
      ST_WAIT_A  = 2'd0,
      ST_WAIT_B  = 2'd1,
      ST_WAIT_OP = 2'd2,
      ST_READY   = 2'd3
   } state_t;

endpackage

// File: rtl/alu_operand_loader_button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Conditions one raw push-button: 2-flop synchronizer, stability counter,
// rising-edge detector.
//   clock   : system clock
//   reset   : asynchronous active-low reset
//   i_btn   : raw button, asynchronous to clock
//   o_level : debounced button level
//   o_press : one-cycle pulse on each accepted press (never on release)
// ---------------------------------------------------------------------------
module button_debouncer
   import alu_operand_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // The level flips on the edge that completes the DEBOUNCE_CYCLES-th
   // differing cycle, i.e. while the counter still shows one less.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         o_level <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= i_btn;
         sync_2  <= sync_1;
         level_d <= o_level;
         if (sync_2 == o_level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            o_level <= sync_2;
            cnt     <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign o_press = o_level & ~level_d;

endmodule

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
// Loads ALU operands A, B and opcode OP from a shared switch bank, one field
// per debounced button press, in the order A -> B -> OP, then flags the set
// valid and holds it stable for the downstream ALU.
//   clock     : system clock
//   reset     : asynchronous active-low reset
//   i_switch  : raw switch value (user holds it static while pressing)
//   i_btn_a   : raw button, load A
//   i_btn_b   : raw button, load B
//   i_btn_op  : raw button, load OP
//   o_A/o_B/o_OP : registered operand/opcode fields
//   o_valid   : high while the operand set is complete (READY)
//   o_state   : current FSM state for LED debug
// ---------------------------------------------------------------------------
module alu_operand_loader
   import alu_operand_loader_pkg::*;
#(
   parameter int N_BITS          = 6,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_BITS-1:0] i_switch,
   input  logic              i_btn_a,
   input  logic              i_btn_b,
   input  logic              i_btn_op,
   output logic [N_BITS-1:0] o_A,
   output logic [N_BITS-1:0] o_B,
   output logic [N_BITS-1:0] o_OP,
   output logic              o_valid,
   output logic [1:0]        o_state
);

   logic   press_a, press_b, press_op;
   // Debounced levels are not needed here; the names keep lint quiet.
   logic   unused_level_a, unused_level_b, unused_level_op;
   state_t state, state_next;
   logic   load_a, load_b, load_op;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clock(clock), .reset(reset), .i_btn(i_btn_a),
      .o_level(unused_level_a), .o_press(press_a)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clock(clock), .reset(reset), .i_btn(i_btn_b),
      .o_level(unused_level_b), .o_press(press_b)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
      .clock(clock), .reset(reset), .i_btn(i_btn_op),
      .o_level(unused_level_op), .o_press(press_op)
   );

   // Only the press matching the current WAIT state is honoured; in READY
   // a press of A restarts the sequence and overrides any other press.
   always_comb begin
      state_next = state;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_op    = 1'b0;
      case (state)
         ST_WAIT_A: begin
            if (press_a) begin
               load_a     = 1'b1;
               state_next = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (press_b) begin
               load_b     = 1'b1;
               state_next = ST_WAIT_OP;
            end
         end
         ST_WAIT_OP: begin
            if (press_op) begin
               load_op    = 1'b1;
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            if (press_a) begin
               load_a     = 1'b1;
               state_next = ST_WAIT_B;
            end else begin
               load_b  = press_b;
               load_op = press_op;
            end
         end
         default: state_next = ST_WAIT_A;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_WAIT_A;
         o_A   <= '0;
         o_B   <= '0;
         o_OP  <= '0;
      end else begin
         state <= state_next;
         if (load_a)  o_A  <= i_switch;
         if (load_b)  o_B  <= i_switch;
         if (load_op) o_OP <= i_switch;
      end
   end

   assign o_valid = (state == ST_READY);
   assign o_state = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES=4. A clean
// button press is modelled as an event landing 2+DEBOUNCE_CYCLES edges after
// the raw rise; the model then applies the load-order rules to abstract
// A/B/OP/state values, which are compared with the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_alu_operand_loader;
   import alu_operand_loader_pkg::*;

   localparam int NB = 6;
   localparam int D  = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [NB-1:0] i_switch = '0;
   logic          i_btn_a = 1'b0;
   logic          i_btn_b = 1'b0;
   logic          i_btn_op = 1'b0;
   logic [NB-1:0] o_A, o_B, o_OP;
   logic          o_valid;
   logic [1:0]    o_state;

   always #5 clock = ~clock;

   alu_operand_loader #(.N_BITS(NB), .DEBOUNCE_CYCLES(D)) dut (
      .clock(clock), .reset(reset), .i_switch(i_switch),
      .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
      .o_A(o_A), .o_B(o_B), .o_OP(o_OP), .o_valid(o_valid), .o_state(o_state)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // press request posted by the stimulus (mask bit0=A, bit1=B, bit2=OP)
   int            req_id = 0;
   int            ev_cyc = 0;
   logic [2:0]    ev_mask = '0;
   logic [NB-1:0] ev_sw = '0;

   // behavioural model
   int            cyc = 0;
   int            done_id = 0;
   logic [NB-1:0] m_a = '0, m_b = '0, m_op = '0;
   int            m_st = 0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_a = '0; m_b = '0; m_op = '0; m_st = 0;
         done_id = req_id;
      end else begin
         cyc++;
         if (req_id != done_id && cyc == ev_cyc) begin
            done_id = req_id;
            if (m_st == 3 && ev_mask[0]) begin
               m_a = ev_sw; m_st = 1;
            end else begin
               case (m_st)
                  0: if (ev_mask[0]) begin m_a  = ev_sw; m_st = 1; end
                  1: if (ev_mask[1]) begin m_b  = ev_sw; m_st = 2; end
                  2: if (ev_mask[2]) begin m_op = ev_sw; m_st = 3; end
                  default: begin
                     if (ev_mask[1]) m_b  = ev_sw;
                     if (ev_mask[2]) m_op = ev_sw;
                  end
               endcase
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("cmp o_A", 32'(o_A), 32'(m_a));
      chk("cmp o_B", 32'(o_B), 32'(m_b));
      chk("cmp o_OP", 32'(o_OP), 32'(m_op));
      chk("cmp o_state", 32'(o_state), 32'(m_st));
      chk("cmp o_valid", 32'(o_valid), 32'(m_st == 3));
   endtask

   task automatic press(input logic [2:0] mask, input logic [NB-1:0] sw);
      @(negedge clock);
      i_switch = sw;
      i_btn_a  = mask[0];
      i_btn_b  = mask[1];
      i_btn_op = mask[2];
      ev_mask  = mask;
      ev_sw    = sw;
      ev_cyc   = cyc + 3 + D;
      req_id++;
      repeat (D + 4) @(negedge clock);
      i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
      repeat (D + 4) @(negedge clock);
   endtask

   task automatic bounce_a();
      @(negedge clock);
      i_switch = 6'd11;
      i_btn_a = 1'b1; @(negedge clock);
      i_btn_a = 1'b0; @(negedge clock);
      i_btn_a = 1'b1; @(negedge clock);
      i_btn_a = 1'b0;
      repeat (2 * D + 4) @(negedge clock);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clock);
            if (chk_en) compare_all();
         end
      join_none

      repeat (3) @(negedge clock);
      chk("reset o_A", 32'(o_A), 0);
      chk("reset o_B", 32'(o_B), 0);
      chk("reset o_OP", 32'(o_OP), 0);
      chk("reset o_valid", 32'(o_valid), 0);
      chk("reset o_state", 32'(o_state), 0);
      reset = 1'b1;
      chk_en = 1'b1;

      // out-of-order B in WAIT_A is ignored, then A takes the same switches
      press(3'b010, 6'd9);
      chk("ooo o_B", 32'(o_B), 0);
      chk("ooo o_state", 32'(o_state), 0);
      press(3'b001, 6'd9);
      chk("ooo then A o_A", 32'(o_A), 9);
      chk("ooo then A o_state", 32'(o_state), 1);

      @(negedge clock); reset = 1'b0;
      @(negedge clock); reset = 1'b1;

      // short glitches never reach the debounced level
      bounce_a();
      chk("bounce o_A", 32'(o_A), 0);
      chk("bounce o_state", 32'(o_state), 0);

      // ordered load
      press(3'b001, 6'd5);
      chk("order o_A", 32'(o_A), 5);
      press(3'b010, 6'd3);
      press(3'b100, OP_ADD);
      chk("order o_A final", 32'(o_A), 5);
      chk("order o_B", 32'(o_B), 3);
      chk("order o_OP", 32'(o_OP), 32'h20);
      chk("order o_valid", 32'(o_valid), 1);
      chk("order o_state", 32'(o_state), 3);

      // reloads from READY
      press(3'b010, 6'd7);
      chk("ready B o_B", 32'(o_B), 7);
      chk("ready B o_state", 32'(o_state), 3);
      press(3'b001, 6'd1);
      chk("ready A o_A", 32'(o_A), 1);
      chk("ready A o_valid", 32'(o_valid), 0);
      chk("ready A o_state", 32'(o_state), 1);

      // simultaneous A+B in READY: A wins
      press(3'b010, 6'd4);
      press(3'b100, OP_SUB);
      chk("back ready o_state", 32'(o_state), 3);
      press(3'b011, 6'd8);
      chk("simul AB o_A", 32'(o_A), 8);
      chk("simul AB o_B", 32'(o_B), 4);
      chk("simul AB o_state", 32'(o_state), 1);

      // simultaneous B+OP in READY: both load
      press(3'b010, 6'd10);
      press(3'b100, OP_AND);
      press(3'b110, 6'd2);
      chk("simul BOP o_B", 32'(o_B), 2);
      chk("simul BOP o_OP", 32'(o_OP), 2);
      chk("simul BOP o_A", 32'(o_A), 8);
      chk("simul BOP o_state", 32'(o_state), 3);

      // reset pulse in WAIT_OP with A held across the release
      press(3'b001, 6'd3);
      press(3'b010, 6'd6);
      chk("pre-reset o_state", 32'(o_state), 2);
      @(negedge clock);
      i_switch = 6'd12;
      i_btn_a  = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk("mid reset o_A", 32'(o_A), 0);
      chk("mid reset o_B", 32'(o_B), 0);
      chk("mid reset o_state", 32'(o_state), 0);
      chk("mid reset o_valid", 32'(o_valid), 0);
      #1 reset = 1'b1;
      ev_mask = 3'b001;
      ev_sw   = 6'd12;
      ev_cyc  = cyc + 3 + D;
      req_id++;
      repeat (D + 4) @(negedge clock);
      chk("held A o_A", 32'(o_A), 12);
      chk("held A o_state", 32'(o_state), 1);
      i_btn_a = 1'b0;
      repeat (D + 4) @(negedge clock);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
